// File: rtl/zbt_pkg.sv
// Shared ZBT constants, pipeline op tags and the sequencer state encoding.
package zbt_pkg;

    // Cycles between the address phase and the data phase on the ZBT bus
    localparam int ZBT_LAT    = 2;
    localparam int ZBT_ADDR_W = 19;
    localparam int ZBT_DATA_W = 36;

    // Tag carried down the data pipeline so each data-phase cycle knows its owner
    typedef enum logic [1:0] {
        OP_NONE  = 2'd0,
        OP_READ  = 2'd1,
        OP_WRITE = 2'd2
    } zbt_op_e;

    // Burst sequencer states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_DRAIN = 2'd2
    } seq_state_e;

endpackage

// File: rtl/zbt_delay_line.sv
// ZBT_LAT-stage shift register carrying {op tag, write data} from the grant
// cycle towards the ZBT data phase. Reset empties every stage so nothing
// issued before reset can reach the bus afterwards.
module zbt_delay_line
    import zbt_pkg::*;
#(
    parameter int DATA_W = ZBT_DATA_W
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  zbt_op_e           i_op,
    input  logic [DATA_W-1:0] i_data,
    output zbt_op_e           o_op,
    output logic [DATA_W-1:0] o_data
);

    zbt_op_e           r_op   [ZBT_LAT];
    logic [DATA_W-1:0] r_data [ZBT_LAT];

    // Shift tag and data one stage per cycle; clear all stages on reset
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int i = 0; i < ZBT_LAT; i++) begin
                r_op[i]   <= OP_NONE;
                r_data[i] <= '0;
            end
        end else begin
            r_op[0]   <= i_op;
            r_data[0] <= i_data;
            for (int i = 1; i < ZBT_LAT; i++) begin
                r_op[i]   <= r_op[i-1];
                r_data[i] <= r_data[i-1];
            end
        end
    end

    assign o_op   = r_op[ZBT_LAT-1];
    assign o_data = r_data[ZBT_LAT-1];

endmodule

// File: rtl/zbt_point_sequencer.sv
// Writes a burst of NUM_POINTS looked-up points to ZBT SRAM at BASE_ADDR+index
// while sharing the port with a read requester that always wins arbitration.
// Timing for a grant in cycle n: address/we_b in n+1, bus data phase in n+3,
// read data returned with rd_valid in n+4. Continuous rd_req starves writes.
module zbt_point_sequencer
    import zbt_pkg::*;
#(
    parameter int                ADDR_W     = ZBT_ADDR_W,
    parameter int                DATA_W     = ZBT_DATA_W,
    parameter int                IDX_W      = 2,
    parameter int                NUM_POINTS = 4,
    parameter logic [ADDR_W-1:0] BASE_ADDR  = '0
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_start,
    output logic              o_busy,
    output logic              o_done,
    output logic [IDX_W-1:0]  o_index,
    input  logic [DATA_W-1:0] i_value,
    input  logic              i_rd_req,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic [DATA_W-1:0] o_rd_data,
    output logic              o_rd_valid,
    output logic [ADDR_W-1:0] o_zbt_addr,
    output logic              o_zbt_we_b,
    output logic [DATA_W-1:0] o_zbt_wdata,
    output logic              o_zbt_wdata_oe,
    input  logic [DATA_W-1:0] i_zbt_rdata,
    output logic [1:0]        o_dbg_state
);

    seq_state_e        r_state;
    seq_state_e        w_next_state;
    logic [IDX_W-1:0]  r_wr_idx;
    logic              r_drain_cnt;
    logic              w_wr_grant;
    logic              w_last;
    logic              w_busy;
    logic              w_done_next;
    logic [IDX_W-1:0]  w_index;
    zbt_op_e           w_op;
    logic [DATA_W-1:0] w_op_data;
    zbt_op_e           w_dl_op;
    logic [DATA_W-1:0] w_dl_data;
    logic [ADDR_W-1:0] r_zbt_addr;
    logic              r_zbt_we_b;
    logic [DATA_W-1:0] r_wdata;
    logic              r_wdata_oe;
    logic              r_rd_pend;
    logic [DATA_W-1:0] r_rd_data;
    logic              r_rd_valid;
    logic              r_done;

    // A write is granted only in WRITE and only when no read is asking
    assign w_wr_grant = (r_state == ST_WRITE) && !i_rd_req;
    assign w_last     = (r_wr_idx == IDX_W'(NUM_POINTS - 1));

    // State register
    always_ff @(posedge i_clk) begin
        if (i_reset) r_state <= ST_IDLE;
        else         r_state <= w_next_state;
    end

    // Next-state logic; start outside IDLE is ignored
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:  if (i_start)                w_next_state = ST_WRITE;
            ST_WRITE: if (w_wr_grant && w_last)   w_next_state = ST_DRAIN;
            ST_DRAIN: if (r_drain_cnt)            w_next_state = ST_IDLE;
            default:                              w_next_state = ST_IDLE;
        endcase
    end

    // FSM outputs and the op/data presented to the data pipeline
    always_comb begin
        w_busy      = (r_state != ST_IDLE);
        w_index     = (r_state == ST_WRITE) ? r_wr_idx : '0;
        w_done_next = (r_state == ST_DRAIN) && r_drain_cnt;
        w_op        = OP_NONE;
        w_op_data   = '0;
        if (i_rd_req) begin
            w_op = OP_READ;
        end else if (w_wr_grant) begin
            w_op      = OP_WRITE;
            w_op_data = i_value;
        end
    end

    // Point index advances on write grants only; drain counter times DRAIN
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_wr_idx    <= '0;
            r_drain_cnt <= 1'b0;
        end else begin
            if (r_state == ST_IDLE)  r_wr_idx <= '0;
            else if (w_wr_grant)     r_wr_idx <= w_last ? '0 : r_wr_idx + 1'b1;
            r_drain_cnt <= (r_state == ST_DRAIN) && !r_drain_cnt;
        end
    end

    // ZBT address phase; address holds on idle cycles, we_b returns high
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_zbt_addr <= '0;
            r_zbt_we_b <= 1'b1;
        end else if (i_rd_req) begin
            r_zbt_addr <= i_rd_addr;
            r_zbt_we_b <= 1'b1;
        end else if (w_wr_grant) begin
            r_zbt_addr <= BASE_ADDR + ADDR_W'(r_wr_idx);
            r_zbt_we_b <= 1'b0;
        end else begin
            r_zbt_we_b <= 1'b1;
        end
    end

    zbt_delay_line #(.DATA_W(DATA_W)) u_delay (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_op    (w_op),
        .i_data  (w_op_data),
        .o_op    (w_dl_op),
        .o_data  (w_dl_data)
    );

    // Data phase: drive the bus only for write tags, flag read tags for capture
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_wdata    <= '0;
            r_wdata_oe <= 1'b0;
            r_rd_pend  <= 1'b0;
        end else begin
            r_wdata    <= (w_dl_op == OP_WRITE) ? w_dl_data : '0;
            r_wdata_oe <= (w_dl_op == OP_WRITE);
            r_rd_pend  <= (w_dl_op == OP_READ);
        end
    end

    // Read capture at the end of the data phase, plus the done pulse
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_rd_valid <= r_rd_pend;
            if (r_rd_pend) r_rd_data <= i_zbt_rdata;
            r_done     <= w_done_next;
        end
    end

    assign o_busy         = w_busy;
    assign o_done         = r_done;
    assign o_index        = w_index;
    assign o_rd_data      = r_rd_data;
    assign o_rd_valid     = r_rd_valid;
    assign o_zbt_addr     = r_zbt_addr;
    assign o_zbt_we_b     = r_zbt_we_b;
    assign o_zbt_wdata    = r_wdata;
    assign o_zbt_wdata_oe = r_wdata_oe;
    assign o_dbg_state    = r_state;

endmodule

// File: tb/tb_zbt_point_sequencer.sv
// Directed bench for zbt_point_sequencer: a ZBT SRAM model on the first
// instance, a second instance with BASE_ADDR near the top of the address space.
module tb_zbt_point_sequencer;

  localparam logic [35:0] TBL [4] = '{36'h12C4B, 36'h19064, 36'h1F47D, 36'h25896};
  localparam logic [35:0] MEM_100 = 36'hABCD12345;
  localparam logic [35:0] RD_B    = 36'hC0FFEE123;

  logic        clk = 1'b0;
  logic        reset, start, rd_req, start_b, rd_req_b;
  logic [18:0] rd_addr, rd_addr_b;
  logic [35:0] value, value_b, zbt_rdata, zbt_rdata_b;
  logic        busy, done, rd_valid, zbt_we_b, zbt_wdata_oe;
  logic        busy_b, done_b, rd_valid_b, zbt_we_b_b, zbt_wdata_oe_b;
  logic [1:0]  index, index_b, dbg_state, dbg_state_b;
  logic [35:0] rd_data, zbt_wdata, rd_data_b, zbt_wdata_b;
  logic [18:0] zbt_addr, zbt_addr_b;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  assign value   = TBL[index];
  assign value_b = TBL[index_b];

  zbt_point_sequencer dut (
    .i_clk(clk), .i_reset(reset), .i_start(start), .o_busy(busy), .o_done(done),
    .o_index(index), .i_value(value), .i_rd_req(rd_req), .i_rd_addr(rd_addr),
    .o_rd_data(rd_data), .o_rd_valid(rd_valid), .o_zbt_addr(zbt_addr),
    .o_zbt_we_b(zbt_we_b), .o_zbt_wdata(zbt_wdata), .o_zbt_wdata_oe(zbt_wdata_oe),
    .i_zbt_rdata(zbt_rdata), .o_dbg_state(dbg_state)
  );

  zbt_point_sequencer #(.BASE_ADDR(19'h7FFFE)) dut_b (
    .i_clk(clk), .i_reset(reset), .i_start(start_b), .o_busy(busy_b), .o_done(done_b),
    .o_index(index_b), .i_value(value_b), .i_rd_req(rd_req_b), .i_rd_addr(rd_addr_b),
    .o_rd_data(rd_data_b), .o_rd_valid(rd_valid_b), .o_zbt_addr(zbt_addr_b),
    .o_zbt_we_b(zbt_we_b_b), .o_zbt_wdata(zbt_wdata_b), .o_zbt_wdata_oe(zbt_wdata_oe_b),
    .i_zbt_rdata(zbt_rdata_b), .o_dbg_state(dbg_state_b)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ZBT SRAM model: address phase in cycle k, data phase in cycle k+2
  logic [35:0] mem [logic [18:0]];
  logic        model_en = 1'b0;
  logic [18:0] s1_a = '0, s2_a = '0;
  logic        s1_w = 1'b0, s2_w = 1'b0, s1_r = 1'b0, s2_r = 1'b0;

  function automatic logic [35:0] mem_rd(input logic [18:0] a);
    return mem.exists(a) ? mem[a] : 36'h0;
  endfunction

  always @(negedge clk) begin
    if (model_en) begin
      chk("oe_vs_tag", zbt_wdata_oe, s2_w);
      if (s2_w) mem[s2_a] = zbt_wdata;
      zbt_rdata = s2_r ? mem_rd(s2_a) : 36'h0;
      s2_a = s1_a; s2_w = s1_w; s2_r = s1_r;
      s1_a = zbt_addr; s1_w = (zbt_we_b === 1'b0); s1_r = (zbt_we_b === 1'b1);
      if (reset) begin
        s1_w = 1'b0; s1_r = 1'b0; s2_w = 1'b0; s2_r = 1'b0;
      end
    end
  end

  // Uncontended 4-point burst on the first instance; dup_c re-pulses start
  task automatic run_burst(input string tag, input int dup_c, input logic [18:0] addr0);
    logic [7:0]  e_busy, e_done, e_we, e_oe;
    int          e_idx [8];
    logic [18:0] e_addr [8];
    logic [35:0] e_wd [8];
    e_busy = 8'b0011_1111;
    e_done = 8'b0100_0000;
    e_we   = 8'b1110_0001;
    e_oe   = 8'b0111_1000;
    e_idx  = '{0, 1, 2, 3, 0, 0, 0, 0};
    e_addr = '{addr0, 19'd0, 19'd1, 19'd2, 19'd3, 19'd3, 19'd3, 19'd3};
    e_wd   = '{36'h0, 36'h0, 36'h0, TBL[0], TBL[1], TBL[2], TBL[3], 36'h0};
    start = 1'b1;
    chk({tag, " pre busy"}, busy, 1'b0);
    tick();
    for (int c = 0; c < 8; c++) begin
      start = (c == dup_c);
      chk($sformatf("%s c%0d busy", tag, c), busy, e_busy[c]);
      chk($sformatf("%s c%0d done", tag, c), done, e_done[c]);
      chk($sformatf("%s c%0d index", tag, c), index, e_idx[c]);
      chk($sformatf("%s c%0d addr", tag, c), zbt_addr, e_addr[c]);
      chk($sformatf("%s c%0d we_b", tag, c), zbt_we_b, e_we[c]);
      chk($sformatf("%s c%0d oe", tag, c), zbt_wdata_oe, e_oe[c]);
      chk($sformatf("%s c%0d wdata", tag, c), zbt_wdata, e_wd[c]);
      chk($sformatf("%s c%0d rd_valid", tag, c), rd_valid, 1'b0);
      tick();
    end
    start = 1'b0;
  endtask

  initial begin
    logic [8:0]  p_busy, p_done, p_we, p_oe, p_rv;
    int          p_idx [9];
    logic [18:0] p_addr [9];
    logic [35:0] p_wd [9];
    logic [18:0] rb_addr [9];
    logic [7:0]  w_busy_e, w_done_e, w_we_e, w_oe_e, w_rv_e;
    int          w_idx [8];
    logic [18:0] w_addr [8];
    logic [35:0] w_wd [8];

    reset = 1'b1; start = 1'b0; rd_req = 1'b0; rd_addr = '0;
    start_b = 1'b0; rd_req_b = 1'b0; rd_addr_b = '0; zbt_rdata_b = '0;
    tick();
    tick();
    chk("rst busy", busy, 1'b0);
    chk("rst done", done, 1'b0);
    chk("rst index", index, 2'd0);
    chk("rst rd_valid", rd_valid, 1'b0);
    chk("rst rd_data", rd_data, 36'h0);
    chk("rst addr", zbt_addr, 19'h0);
    chk("rst we_b", zbt_we_b, 1'b1);
    chk("rst wdata", zbt_wdata, 36'h0);
    chk("rst oe", zbt_wdata_oe, 1'b0);
    chk("rst state", dbg_state, 2'd0);
    chk("rst b busy", busy_b, 1'b0);
    chk("rst b we_b", zbt_we_b_b, 1'b1);
    chk("rst b oe", zbt_wdata_oe_b, 1'b0);
    reset = 1'b0;
    model_en = 1'b1;
    tick();

    // Basic burst straight out of reset
    run_burst("basic", -1, 19'd0);

    // Read the four points back, one request per cycle
    rb_addr = '{19'd3, 19'd0, 19'd1, 19'd2, 19'd3, 19'd3, 19'd3, 19'd3, 19'd3};
    for (int r = 0; r < 9; r++) begin
      rd_req  = (r < 4);
      rd_addr = 19'(r);
      chk($sformatf("rdbk r%0d rd_valid", r), rd_valid, (r >= 4 && r <= 7));
      if (r >= 4 && r <= 7) chk($sformatf("rdbk r%0d rd_data", r), rd_data, TBL[r-4]);
      chk($sformatf("rdbk r%0d addr", r), zbt_addr, rb_addr[r]);
      chk($sformatf("rdbk r%0d we_b", r), zbt_we_b, 1'b1);
      tick();
    end
    rd_req = 1'b0;

    // Read inserted in the cycle after index 1 is granted
    mem[19'h100] = MEM_100;
    p_busy = 9'b0_0111_1111;
    p_done = 9'b0_1000_0000;
    p_we   = 9'b1_1100_1001;
    p_oe   = 9'b0_1101_1000;
    p_rv   = 9'b0_0100_0000;
    p_idx  = '{0, 1, 2, 2, 3, 0, 0, 0, 0};
    p_addr = '{19'd3, 19'd0, 19'd1, 19'h100, 19'd2, 19'd3, 19'd3, 19'd3, 19'd3};
    p_wd   = '{36'h0, 36'h0, 36'h0, TBL[0], TBL[1], 36'h0, TBL[2], TBL[3], 36'h0};
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 0; c < 9; c++) begin
      rd_req  = (c == 2);
      rd_addr = 19'h100;
      chk($sformatf("prio c%0d busy", c), busy, p_busy[c]);
      chk($sformatf("prio c%0d done", c), done, p_done[c]);
      chk($sformatf("prio c%0d index", c), index, p_idx[c]);
      chk($sformatf("prio c%0d addr", c), zbt_addr, p_addr[c]);
      chk($sformatf("prio c%0d we_b", c), zbt_we_b, p_we[c]);
      chk($sformatf("prio c%0d oe", c), zbt_wdata_oe, p_oe[c]);
      chk($sformatf("prio c%0d wdata", c), zbt_wdata, p_wd[c]);
      chk($sformatf("prio c%0d rd_valid", c), rd_valid, p_rv[c]);
      if (p_rv[c]) chk($sformatf("prio c%0d rd_data", c), rd_data, MEM_100);
      tick();
    end
    rd_req = 1'b0;

    // Second start pulse mid-burst must be ignored
    run_burst("dupstart", 2, 19'd3);
    chk("dupstart post done", done, 1'b0);

    // Reset one cycle after the second write grant
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("rstmid c0 busy", busy, 1'b1);
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rstmid we_b", zbt_we_b, 1'b1);
    chk("rstmid oe", zbt_wdata_oe, 1'b0);
    chk("rstmid busy", busy, 1'b0);
    chk("rstmid index", index, 2'd0);
    chk("rstmid addr", zbt_addr, 19'h0);
    for (int c = 0; c < 6; c++) begin
      tick();
      chk($sformatf("rstmid q%0d done", c), done, 1'b0);
      chk($sformatf("rstmid q%0d oe", c), zbt_wdata_oe, 1'b0);
      chk($sformatf("rstmid q%0d rd_valid", c), rd_valid, 1'b0);
      chk($sformatf("rstmid q%0d busy", c), busy, 1'b0);
    end
    run_burst("after_rst", -1, 19'd0);

    // Start together with a read in IDLE, addresses wrapping past the top
    w_busy_e = 8'b0011_1111;
    w_done_e = 8'b0100_0000;
    w_we_e   = 8'b1110_0001;
    w_oe_e   = 8'b0111_1000;
    w_rv_e   = 8'b0000_1000;
    w_idx    = '{0, 1, 2, 3, 0, 0, 0, 0};
    w_addr   = '{19'h00055, 19'h7FFFE, 19'h7FFFF, 19'h00000, 19'h00001, 19'h00001, 19'h00001, 19'h00001};
    w_wd     = '{36'h0, 36'h0, 36'h0, TBL[0], TBL[1], TBL[2], TBL[3], 36'h0};
    start_b = 1'b1;
    rd_req_b = 1'b1;
    rd_addr_b = 19'h00055;
    chk("wrap pre busy", busy_b, 1'b0);
    tick();
    start_b = 1'b0;
    rd_req_b = 1'b0;
    for (int c = 0; c < 8; c++) begin
      zbt_rdata_b = (c == 2) ? RD_B : 36'h0;
      chk($sformatf("wrap c%0d busy", c), busy_b, w_busy_e[c]);
      chk($sformatf("wrap c%0d done", c), done_b, w_done_e[c]);
      chk($sformatf("wrap c%0d index", c), index_b, w_idx[c]);
      chk($sformatf("wrap c%0d addr", c), zbt_addr_b, w_addr[c]);
      chk($sformatf("wrap c%0d we_b", c), zbt_we_b_b, w_we_e[c]);
      chk($sformatf("wrap c%0d oe", c), zbt_wdata_oe_b, w_oe_e[c]);
      chk($sformatf("wrap c%0d wdata", c), zbt_wdata_b, w_wd[c]);
      chk($sformatf("wrap c%0d rd_valid", c), rd_valid_b, w_rv_e[c]);
      if (w_rv_e[c]) chk($sformatf("wrap c%0d rd_data", c), rd_data_b, RD_B);
      tick();
    end
    zbt_rdata_b = '0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
